// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit teaching processor controller: opcodes,
// FSM states and the bit positions of the 8-bit instruction fields.
package cpu_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LI   = 2'b10;
    localparam logic [1:0] OP_BEQZ = 2'b11;

    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int RD_HI  = 5;
    localparam int RD_LO  = 4;
    localparam int RS_HI  = 3;
    localparam int RS_LO  = 2;
    localparam int RT_HI  = 1;
    localparam int RT_LO  = 0;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALTED
    } state_t;

endpackage

// File: rtl/alu4.sv
// Combinational 4-bit ALU: add/sub modulo 16, immediate pass-through for LI,
// and a zero flag on operand a used for the BEQZ branch decision.
import cpu_pkg::*;

module alu4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] imm,
    input  logic [1:0] op,
    output logic [3:0] y,
    output logic       zero
);

    always_comb begin
        y = 4'd0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_LI:   y = imm;
            OP_BEQZ: y = a;
            default: y = 4'd0;
        endcase
    end

    assign zero = (a == 4'd0);

endmodule

// File: rtl/control_unit.sv
// Fetch/latch/execute/writeback controller for the 4-bit teaching processor.
//   state     | meaning
//   IDLE      | after reset, waiting for start
//   FETCH     | imem_addr holds pc, ROM access in flight
//   LATCH     | ROM data captured into ir
//   EXECUTE   | register reads valid, result and branch flag captured
//   WRITEBACK | write strobe for ADD/SUB/LI, pc advances or halts
//   HALTED    | taken self-branch seen, pc held until start
import cpu_pkg::*;

module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [3:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic [1:0] read_addr1,
    output logic [1:0] read_addr2,
    input  logic [3:0] read_data1,
    input  logic [3:0] read_data2,
    output logic [1:0] write_addr,
    output logic [3:0] write_data,
    output logic       write_enable,
    output logic [3:0] pc,
    output logic       busy,
    output logic       halted
);

    state_t     state, state_next;
    logic [7:0] ir;
    logic [3:0] result;
    logic       take;

    logic [1:0] op;
    logic [1:0] rd, rs, rt;
    logic [3:0] imm;
    logic [3:0] alu_y;
    logic       alu_zero;
    logic [3:0] pc_next;
    logic       is_halt;

    assign op  = ir[OP_HI:OP_LO];
    assign rd  = ir[RD_HI:RD_LO];
    assign rs  = ir[RS_HI:RS_LO];
    assign rt  = ir[RT_HI:RT_LO];
    assign imm = ir[IMM_HI:IMM_LO];

    alu4 u_alu (
        .a    (read_data1),
        .b    (read_data2),
        .imm  (imm),
        .op   (op),
        .y    (alu_y),
        .zero (alu_zero)
    );

    // A taken branch onto its own address would spin forever; treat it as halt.
    assign is_halt = (op == OP_BEQZ) && take && (imm == pc);
    assign pc_next = ((op == OP_BEQZ) && take) ? imm : pc + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            pc        <= 4'd0;
            imem_addr <= 4'd0;
            ir        <= 8'd0;
            result    <= 4'd0;
            take      <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        pc        <= 4'd0;
                        imem_addr <= 4'd0;
                    end
                end
                ST_LATCH: ir <= imem_data;
                ST_EXECUTE: begin
                    result <= alu_y;
                    take   <= alu_zero;
                end
                ST_WRITEBACK: begin
                    if (!is_halt) begin
                        pc        <= pc_next;
                        imem_addr <= pc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next   = state;
        read_addr1   = 2'd0;
        read_addr2   = 2'd0;
        write_enable = 1'b0;
        write_addr   = 2'd0;
        write_data   = 4'd0;
        busy         = 1'b1;
        halted       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_next = ST_FETCH;
            end
            ST_FETCH: state_next = ST_LATCH;
            ST_LATCH: state_next = ST_EXECUTE;
            ST_EXECUTE: begin
                read_addr1 = (op == OP_BEQZ) ? rd : rs;
                read_addr2 = rt;
                state_next = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                if (op != OP_BEQZ) begin
                    write_enable = 1'b1;
                    write_addr   = rd;
                    write_data   = result;
                end
                state_next = is_halt ? ST_HALTED : ST_FETCH;
            end
            ST_HALTED: begin
                busy   = 1'b0;
                halted = 1'b1;
                if (start) state_next = ST_FETCH;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench: an instruction-level model of the processor predicts each
// instruction's fetch pc, register reads and write-back; a monitor checks them.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] imem_addr;
    logic [7:0] imem_data;
    logic [1:0] read_addr1, read_addr2, write_addr;
    logic [3:0] read_data1, read_data2, write_data, pc;
    logic       write_enable, busy, halted;

    int n_tests = 0;
    int n_fail  = 0;

    control_unit dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .read_addr1   (read_addr1),
        .read_addr2   (read_addr2),
        .read_data1   (read_data1),
        .read_data2   (read_data2),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_enable (write_enable),
        .pc           (pc),
        .busy         (busy),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [16];
    logic [3:0] rf [4];

    always @(posedge clk) imem_data <= rom[imem_addr];
    always @(posedge clk) if (write_enable) rf[write_addr] <= write_data;
    assign read_data1 = rf[read_addr1];
    assign read_data2 = rf[read_addr2];

    typedef struct {
        int pc;
        bit we;
        int wa;
        int wd;
        bit ra1_chk;
        int ra1;
        int ra2;
    } rec_t;

    rec_t q[$];
    int   m_rf [4];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Instruction-level semantics of one instruction at address mpc.
    function automatic rec_t decode(input logic [7:0] ir, input int mpc);
        rec_t r;
        int op, rd, rs, rt, imm;
        op = int'(ir[7:6]); rd = int'(ir[5:4]); rs = int'(ir[3:2]);
        rt = int'(ir[1:0]); imm = int'(ir[3:0]);
        r.pc = mpc; r.we = (op != 3); r.wa = rd; r.ra2 = rt;
        r.ra1_chk = (op != 2);
        r.ra1 = (op == 3) ? rd : rs;
        case (op)
            0: r.wd = (m_rf[rs] + m_rf[rt]) % 16;
            1: r.wd = (m_rf[rs] - m_rf[rt] + 16) % 16;
            2: r.wd = imm;
            default: r.wd = 0;
        endcase
        return r;
    endfunction

    // Monitor: four-cycle instruction frames counted from the rise of busy.
    int   phase = 0;
    rec_t cur;
    bit   have = 0;
    always @(negedge clk) begin
        if (reset || !busy) begin
            phase = 0;
            have  = 0;
            if (write_enable) chk("we_idle", 1, 0);
        end else begin
            case (phase)
                0: begin
                    if (q.size() == 0) begin
                        chk("unexpected_fetch", int'(pc), -1);
                        have = 0;
                    end else begin
                        cur  = q.pop_front();
                        have = 1;
                        chk("fetch_pc", int'(pc), cur.pc);
                        chk("fetch_imem_addr", int'(imem_addr), cur.pc);
                    end
                    chk("we_fetch", int'(write_enable), 0);
                end
                1: chk("we_latch", int'(write_enable), 0);
                2: begin
                    chk("we_exec", int'(write_enable), 0);
                    if (have) begin
                        if (cur.ra1_chk) chk("read_addr1", int'(read_addr1), cur.ra1);
                        chk("read_addr2", int'(read_addr2), cur.ra2);
                    end
                end
                default: begin
                    if (have) begin
                        chk("wb_we", int'(write_enable), int'(cur.we));
                        if (cur.we) begin
                            chk("wb_addr", int'(write_addr), cur.wa);
                            chk("wb_data", int'(write_data), cur.wd);
                        end
                    end
                end
            endcase
            phase = (phase + 1) % 4;
        end
    end

    task automatic check_reset_values();
        chk("rst_imem_addr", int'(imem_addr), 0);
        chk("rst_pc", int'(pc), 0);
        chk("rst_read_addr1", int'(read_addr1), 0);
        chk("rst_read_addr2", int'(read_addr2), 0);
        chk("rst_write_addr", int'(write_addr), 0);
        chk("rst_write_data", int'(write_data), 0);
        chk("rst_write_enable", int'(write_enable), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_halted", int'(halted), 0);
    endtask

    // Run the ROM for up to n_max instructions; if it has not halted by then,
    // assert reset p cycles into instruction n_max.
    task automatic run_prog(input int n_max, input int p);
        int   mpc, n;
        bit   mh;
        rec_t r;
        int   op, rd, imm;
        for (int i = 0; i < 4; i++) m_rf[i] = int'(rf[i]);
        mpc = 0; mh = 0; n = 0;
        while (n < n_max && !mh) begin
            r = decode(rom[mpc], mpc);
            q.push_back(r);
            op = int'(rom[mpc][7:6]); rd = int'(rom[mpc][5:4]); imm = int'(rom[mpc][3:0]);
            if (op == 3) begin
                if (m_rf[rd] == 0 && imm == mpc) mh = 1;
                else if (m_rf[rd] == 0) mpc = imm;
                else mpc = (mpc + 1) % 16;
            end else begin
                m_rf[r.wa] = r.wd;
                mpc = (mpc + 1) % 16;
            end
            n++;
        end
        if (!mh && p >= 1) q.push_back(decode(rom[mpc], mpc));

        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (mh) begin
            for (int i = 0; i < 4 * n + 12 && !halted; i++) @(negedge clk);
            chk("halted", int'(halted), 1);
            chk("halt_busy", int'(busy), 0);
            chk("halt_pc", int'(pc), mpc);
            repeat (3) @(negedge clk);
            chk("halt_pc_hold", int'(pc), mpc);
        end else begin
            repeat (4 * n + p) @(posedge clk);
            #1 reset = 1'b1;
            @(negedge clk);
            check_reset_values();
            @(negedge clk);
            reset = 1'b0;
        end
        chk("scoreboard_drained", q.size(), 0);
        q.delete();
        for (int i = 0; i < 4; i++) chk("regfile", int'(rf[i]), m_rf[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4; i++) rf[i] = 4'($urandom);
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values();
        reset = 1'b0;

        // LI R1,5 first; then LI R0,0 and halt at 2
        rom[0] = 8'h95; rom[1] = 8'h80; rom[2] = 8'hC2;
        run_prog(10, 0);

        // LI/LI/ADD wrap/SUB 15/BEQZ not-taken/LI R0,0/BEQZ taken to 10/halt at 10
        rom[0] = 8'h99; rom[1] = 8'hA8; rom[2] = 8'h36; rom[3] = 8'h49;
        rom[4] = 8'hC6; rom[5] = 8'h80; rom[6] = 8'hCA; rom[10] = 8'hCA;
        run_prog(20, 0);
        run_prog(20, 0);
        // reset during EXECUTE of the ADD
        run_prog(2, 2);

        // halt at pc=4
        rom[0] = 8'h80; rom[1] = 8'h91; rom[2] = 8'h91; rom[3] = 8'h91; rom[4] = 8'hC4;
        run_prog(10, 0);
        run_prog(10, 0);

        // straight-line program wrapping past pc 15
        for (int i = 0; i < 16; i++) rom[i] = {2'($urandom_range(0, 2)), 6'($urandom)};
        run_prog(20, 1);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
            run_prog($urandom_range(1, 25), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
